// File: rtl/bhr_ckpt_pkg.sv
// Shared fetch-side constants and types for branch-history checkpointing.
package bhr_ckpt_pkg;
  localparam int BHR_W = 16;
  localparam int DEPTH = 16;
  localparam int ID_W  = 4;
  localparam int RET_W = 4;

  typedef logic [ID_W-1:0] ckpt_id_t;
  typedef logic [ID_W:0]   ckpt_ptr_t;
endpackage

// File: rtl/bhr_ckpt_ram.sv
// Checkpoint storage: one write port, one registered read port.
module bhr_ckpt_ram
  import bhr_ckpt_pkg::*;
#(
  parameter int W_DEPTH = DEPTH,
  parameter int W_BHR   = BHR_W,
  parameter int W_ID    = ID_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [W_ID-1:0]   i_waddr,
  input  logic [W_BHR-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [W_ID-1:0]   i_raddr,
  output logic [W_BHR-1:0]  o_rdata
);
  logic [W_BHR-1:0] r_mem [W_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register is reset so the exported snapshot is 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/bhr_ckpt_ctrl.sv
// In-order BHR checkpoint manager: allocate at predict, free at retire, repair on mispredict.
module bhr_ckpt_ctrl
  import bhr_ckpt_pkg::*;
#(
  parameter int P_BHR_W = BHR_W,
  parameter int P_DEPTH = DEPTH,
  parameter int P_ID_W  = ID_W,
  parameter int P_RET_W = RET_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                alloc_i,
  input  logic [P_BHR_W-1:0]  alloc_bhr_i,
  output logic                alloc_ready_o,
  output logic [P_ID_W-1:0]   alloc_id_o,
  input  logic [2:0]          retire_cnt_i,
  input  logic                recover_i,
  input  logic [P_ID_W-1:0]   recover_id_i,
  output logic                recover_valid_o,
  output logic [P_BHR_W-1:0]  recover_bhr_o,
  output logic [P_ID_W:0]     count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                err_o
);
  logic [P_ID_W:0]   r_head, r_tail;
  logic              r_err, r_rvalid;
  logic [P_ID_W:0]   w_count, w_ret_ext, w_ret_eff, w_new_head;
  logic [P_ID_W:0]   w_rec_keep, w_rec_tail, w_tail_nxt;
  logic [P_ID_W-1:0] w_rec_off;
  logic              w_full, w_alloc, w_ret_big, w_ret_over;
  logic              w_rec_in, w_rec_over, w_rec_err;

  assign w_count   = r_tail - r_head;
  assign w_full    = (w_count == (P_ID_W+1)'(P_DEPTH));
  assign w_alloc   = alloc_i & ~stall_i & ~w_full & ~recover_i;

  assign w_ret_ext  = (P_ID_W+1)'(retire_cnt_i);
  assign w_ret_big  = (retire_cnt_i > 3'(P_RET_W));
  assign w_ret_over = (w_ret_ext > w_count);
  assign w_ret_eff  = w_ret_over ? w_count : w_ret_ext;
  assign w_new_head = r_head + w_ret_eff;

  // Distance of the mispredicted entry from head; live iff it is below count.
  assign w_rec_off  = recover_id_i - r_head[P_ID_W-1:0];
  assign w_rec_keep = {1'b0, w_rec_off} + 1'b1;
  assign w_rec_in   = ({1'b0, w_rec_off} < w_count);
  assign w_rec_tail = r_head + w_rec_keep;
  assign w_rec_over = (w_ret_eff > w_rec_keep);
  assign w_rec_err  = recover_i & (~w_rec_in | w_rec_over);

  always_comb begin
    w_tail_nxt = r_tail;
    if (recover_i) begin
      if (!w_rec_in)       w_tail_nxt = r_tail;
      else if (w_rec_over) w_tail_nxt = w_new_head;
      else                 w_tail_nxt = w_rec_tail;
    end else if (w_alloc) begin
      w_tail_nxt = r_tail + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_head   <= w_new_head;
      r_tail   <= w_tail_nxt;
      r_err    <= r_err | w_ret_big | w_ret_over | w_rec_err;
      r_rvalid <= recover_i;
    end
  end

  bhr_ckpt_ram #(
    .W_DEPTH(P_DEPTH), .W_BHR(P_BHR_W), .W_ID(P_ID_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_alloc),
    .i_waddr (r_tail[P_ID_W-1:0]),
    .i_wdata (alloc_bhr_i),
    .i_re    (recover_i),
    .i_raddr (recover_id_i),
    .o_rdata (recover_bhr_o)
  );

  assign alloc_ready_o   = ~w_full;
  assign alloc_id_o      = r_tail[P_ID_W-1:0];
  assign count_o         = w_count;
  assign full_o          = w_full;
  assign empty_o         = (w_count == '0);
  assign err_o           = r_err;
  assign recover_valid_o = r_rvalid;
endmodule

// File: tb/tb_bhr_ckpt_ctrl.sv
// Random + directed bench for bhr_ckpt_ctrl against a queue-based reference model.
module tb_bhr_ckpt_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        stall_i = 0, alloc_i = 0, recover_i = 0;
  logic [15:0] alloc_bhr_i = '0;
  logic [2:0]  retire_cnt_i = '0;
  logic [3:0]  recover_id_i = '0;
  logic        alloc_ready_o, recover_valid_o, full_o, empty_o, err_o;
  logic [3:0]  alloc_id_o;
  logic [15:0] recover_bhr_o;
  logic [4:0]  count_o;

  bhr_ckpt_ctrl dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .alloc_i(alloc_i),
    .alloc_bhr_i(alloc_bhr_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
    .retire_cnt_i(retire_cnt_i), .recover_i(recover_i), .recover_id_i(recover_id_i),
    .recover_valid_o(recover_valid_o), .recover_bhr_o(recover_bhr_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // Model: live checkpoints as a queue of snapshots, oldest first.
  logic [15:0] q[$];
  int          mhead = 0;
  logic        merr = 0, mrv = 0;
  logic [15:0] mrbhr = '0;
  logic [15:0] mmem [16];
  bit          mknown [16];
  bit          mrknown = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz = q.size();
    chk("alloc_id", 32'(alloc_id_o), 32'((mhead + sz) % 16));
    chk("ready",    32'(alloc_ready_o), 32'(sz < 16));
    chk("count",    32'(count_o), 32'(sz));
    chk("full",     32'(full_o), 32'(sz == 16));
    chk("empty",    32'(empty_o), 32'(sz == 0));
    chk("err",      32'(err_o), 32'(merr));
    chk("rvalid",   32'(recover_valid_o), 32'(mrv));
    if (mrv && mrknown) chk("rbhr", 32'(recover_bhr_o), 32'(mrbhr));
  endtask

  task automatic model_update(input bit a, input logic [15:0] b, input bit s,
                              input int r, input bit rc, input int rid);
    int sz = q.size();
    int reff = (r < sz) ? r : sz;
    int pos = -1;
    if (r > 4 || r > sz) merr = 1;
    mrv = rc;
    if (rc) begin
      mrbhr = mmem[rid]; mrknown = mknown[rid];
      for (int i = 0; i < sz; i++) if ((mhead + i) % 16 == rid) pos = i;
      if (pos < 0) merr = 1;
      else if (reff > pos + 1) begin merr = 1; q.delete(); end
      else while (q.size() > pos + 1) void'(q.pop_back());
    end else if (a && !s && sz < 16) begin
      mmem[(mhead + sz) % 16] = b; mknown[(mhead + sz) % 16] = 1;
      q.push_back(b);
    end
    for (int i = 0; i < reff; i++) if (q.size() > 0) void'(q.pop_front());
    mhead = (mhead + reff) % 16;
  endtask

  task automatic step(input bit a, input logic [15:0] b, input bit s,
                      input int r, input bit rc, input int rid);
    @(negedge clk);
    check_all();
    alloc_i = a; alloc_bhr_i = b; stall_i = s;
    retire_cnt_i = 3'(r); recover_i = rc; recover_id_i = 4'(rid);
    @(posedge clk);
    model_update(a, b, s, r, rc, rid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; alloc_i = 0; stall_i = 0; retire_cnt_i = 0; recover_i = 0;
    q.delete(); mhead = 0; merr = 0; mrv = 0; mrbhr = '0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mmem[i] = '0; mknown[i] = 0; end
    do_reset();
    // reset state
    @(negedge clk); check_all();
    chk("rst_bhr", 32'(recover_bhr_o), 32'h0);

    step(1, 16'h1111, 0, 0, 0, 0);
    step(1, 16'h2222, 0, 0, 0, 0);
    step(1, 16'h3333, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // fill, blocked 17th, then retire 4
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 16'($urandom), 0, 0, 0, 0);
    step(1, 16'hdead, 0, 0, 0, 0);
    step(0, 0, 0, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // recover id 2 of 0..5, then alloc gets id 3
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 16'h0a00 + 16'(i), 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2);
    step(1, 16'hbeef, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // recover + alloc + retire in one cycle
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 16'h0b00 + 16'(i), 0, 0, 0, 0);
    step(1, 16'hcafe, 0, 2, 1, 4);
    step(0, 0, 0, 0, 0, 0);

    // steady 1/1 flow across the wrap point, then recover across it
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 16'($urandom), 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 16'($urandom), 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, (mhead + 2) % 16);
    step(0, 0, 0, 0, 0, 0);

    // protocol errors, then reset while recover_valid_o is high
    do_reset();
    step(1, 16'h7777, 0, 0, 0, 0);
    step(0, 0, 0, 3, 0, 0);
    step(1, 16'h1234, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, (mhead + 5) % 16);
    #2;
    chk("rv_before_rst", 32'(recover_valid_o), 32'h1);
    reset = 1; recover_i = 0; retire_cnt_i = 0; alloc_i = 0;
    #1;
    chk("async_rv",    32'(recover_valid_o), 32'h0);
    chk("async_bhr",   32'(recover_bhr_o), 32'h0);
    chk("async_err",   32'(err_o), 32'h0);
    chk("async_count", 32'(count_o), 32'h0);
    chk("async_ready", 32'(alloc_ready_o), 32'h1);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int sz = q.size();
      int r  = ($urandom % 25 == 0) ? int'($urandom % 8)
                                    : int'($urandom_range(0, (sz < 3) ? sz : 3));
      bit rc = ($urandom % 10 == 0);
      int rid = (sz > 0 && $urandom % 4 != 0) ? (mhead + int'($urandom % sz)) % 16
                                              : int'($urandom % 16);
      if (n == 200) do_reset();
      step($urandom % 4 != 0, 16'($urandom), $urandom % 5 == 0, r, rc, rid);
    end
    step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/bhr_ckpt_ctrl.md
Name: bhr_ckpt_ctrl

Overview:
Checkpoint manager for branch-history-register snapshots. Fetch allocates one in-order checkpoint per predicted branch, capturing the speculative history at prediction time. The control queue frees checkpoints at retire, up to `RETIRE_WIDTH` per cycle. On a mispredict, the block returns the snapshot of the offending branch so fetch can repair its history, and it squashes every younger checkpoint.

Parameters:
- BHR_W, 16, width of one history snapshot (matches `SIZE_CNT_TBL_LOG`).
- DEPTH, 16, number of checkpoint entries; must be a power of 2.
- ID_W, 4, log2(DEPTH); width of a checkpoint ID.
- RET_W, 4, maximum retires per cycle (matches `RETIRE_WIDTH`).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stall_i  in  1  fetch stall; blocks allocation only.
- alloc_i  in  1  request to allocate a checkpoint this cycle.
- alloc_bhr_i  in  BHR_W  history value to snapshot.
- alloc_ready_o  out  1  asserted when ~full.
- alloc_id_o  out  ID_W  ID granted to the current allocation; equals the current tail pointer.
- retire_cnt_i  in  3  number of oldest checkpoints freed this cycle (0..RET_W).
- recover_i  in  1  mispredict recovery request.
- recover_id_i  in  ID_W  checkpoint ID of the mispredicted branch.
- recover_valid_o  out  1  registered pulse, one cycle after recover_i.
- recover_bhr_o  out  BHR_W  snapshot of recover_id_i; valid while recover_valid_o is high.
- count_o  out  ID_W+1  number of live checkpoints.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- **Storage and pointers.** Storage is DEPTH x BHR_W registers. head_ptr and tail_ptr are each ID_W+1 bits; the MSB is a wrap bit. count = tail_ptr - head_ptr, modulo 2^(ID_W+1).
- **Reset (asynchronous).**
  - head_ptr = tail_ptr = 0; count_o = 0; empty_o = 1; full_o = 0; alloc_ready_o = 1.
  - recover_valid_o = 0; recover_bhr_o = 0; err_o = 0.
  - Storage contents are don't-care.
  - Reset asserted mid-recovery drops recover_valid_o immediately.
- **Allocation.**
  - Occurs when alloc_i & ~stall_i & ~full & ~recover_i.
  - Effect: mem[tail[ID_W-1:0]] <= alloc_bhr_i; tail_ptr += 1.
  - alloc_id_o is combinational from tail_ptr and is valid in the same cycle.
  - alloc_i while full: no write, no pointer change, no error; the requester must observe alloc_ready_o.
- **Retire.**
  - head_ptr += retire_cnt_i every cycle, independent of stall_i.
  - retire_cnt_i > RET_W, or retire_cnt_i > count (using pre-update values): set err_o, clamp the advance to count.
- **Recovery.**
  - On recover_i: tail_ptr <= head-relative pointer of recover_id_i + 1. The mispredicted branch's own entry stays live; all younger entries are squashed.
  - Next cycle: recover_bhr_o <= mem[recover_id_i] and recover_valid_o = 1 for exactly one cycle.
  - recover_id_i must lie in [head, tail). If it does not: set err_o and leave tail_ptr unchanged; the readout still occurs.
  - The recovered snapshot is the pre-branch history; the consumer shifts in the corrected direction.
- **Priority when events coincide.**
  - recover_i beats alloc_i. The allocation is dropped, and its entry is not written.
  - Retire in the same cycle as recover still applies.
  - Same-cycle retire and recover: new count = (recover_ptr + 1) - new_head.
  - If retire consumes the recovered entry, the result is count 0. If retire goes beyond the recovered entry, set err_o and force tail_ptr = new head.
  - Alloc and retire in the same cycle: both apply. Count changes by 1 - retire_cnt.
  - Alloc with retire while full: alloc is still blocked, because full is evaluated on pre-update state.
- **Pointer wrap.** Pointers wrap naturally through the extra MSB. The entry index is ptr[ID_W-1:0].
- **Status outputs.** full_o, empty_o and count_o are registered-state derived, with no combinational path from inputs.
- **Error flag.** err_o is cleared only by reset.
- **Latency.**
  - Alloc ID: 0 cycles.
  - Recovery data: 1 cycle.
  - Status outputs: updated 1 cycle after the causing event.

Decomposition:
- Shared fetch package holds:
  - BHR_W and the checkpoint ID width.
  - RET_W, tied to `RETIRE_WIDTH`.
  - The ckpt_id typedef.
- One sub-module: bhr_ckpt_ram. DEPTH x BHR_W, 1 write port, 1 registered read port. It isolates storage so a later SRAM swap is local.
- Pointer, count and error logic stays in bhr_ckpt_ctrl.

Test Plan:
- Alloc 3 entries (bhr 0x1111, 0x2222, 0x3333), no stall -> alloc_id_o 0, 1, 2; count_o = 3; empty_o = 0.
- Fill 16 allocs -> full_o = 1, alloc_ready_o = 0. A 17th alloc_i -> count stays 16, err_o = 0. Then retire_cnt = 4 -> count = 12, full_o = 0.
- Live IDs 0..5, recover_id = 2 -> next cycle recover_valid_o = 1, recover_bhr_o = mem[2]; count = 3. The next alloc gets ID 3.
- Same cycle: recover_id = 4 with live 0..7, alloc_i = 1 and retire_cnt = 2 -> alloc dropped, head = 2, tail = 5, count = 3.
- Wrap test: 40 alloc/retire cycles at a rate of 1/1 -> IDs wrap 15 -> 0; count is constant at steady state; recovery across the wrap point returns the correct snapshot.
- Error cases: retire_cnt = 3 with count = 1, and recover_id outside the live range -> err_o = 1 sticky, head clamps to tail, tail unchanged. Assert reset during recover_valid_o -> all outputs return to reset values asynchronously.
